// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one byte-wide synchronous memory between the fetch and
// data ports; each granted word access becomes four little-endian byte cycles.
module mem_port_arbiter #(
    parameter int unsigned N = 32,
    parameter int unsigned M = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           halted,
    input  logic           if_req,
    input  logic [M+1:0]   if_addr,
    output logic           if_gnt,
    output logic           if_rvalid,
    output logic [N-1:0]   if_rdata,
    input  logic           d_req,
    input  logic           d_we,
    input  logic [M+1:0]   d_addr,
    input  logic [N-1:0]   d_wdata,
    output logic           d_gnt,
    output logic           d_done,
    output logic [N-1:0]   d_rdata,
    output logic [M+1:0]   mem_addr,
    output logic           mem_we,
    output logic [7:0]     mem_wdata,
    input  logic [7:0]     mem_rdata,
    output logic           busy
);

    typedef enum logic [1:0] {StIdle, StXfer, StDrain} state_e;

    state_e       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [M-1:0] base_q;
    logic         we_q;
    logic         src_data_q;
    logic         last_data_q;
    logic [N-1:0] wdata_q;
    logic [23:0]  buf_q;
    logic         if_elig;

    assign if_elig  = if_req && !halted;
    assign mem_addr = {base_q, cnt_q};
    assign busy     = (state_q != StIdle);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        unique case (state_q)
            StIdle: begin
                // Gate with reset so grants stay low while reset is asserted.
                if (rst) begin
                    if (if_elig && d_req) begin
                        if (last_data_q) if_gnt = 1'b1;
                        else             d_gnt  = 1'b1;
                    end else if (if_elig) begin
                        if_gnt = 1'b1;
                    end else if (d_req) begin
                        d_gnt = 1'b1;
                    end
                end
                if (if_gnt || d_gnt) begin
                    state_d = StXfer;
                    cnt_d   = 2'd0;
                end
            end
            StXfer: begin
                mem_we = we_q;
                if (we_q) mem_wdata = wdata_q[{cnt_q, 3'b000} +: 8];
                // cnt stays at 3 afterwards so mem_addr holds its last value.
                if (cnt_q == 2'd3) state_d = we_q ? StIdle : StDrain;
                else               cnt_d   = cnt_q + 2'd1;
            end
            StDrain: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q      <= '0;
            we_q        <= 1'b0;
            src_data_q  <= 1'b0;
            last_data_q <= 1'b1;
            wdata_q     <= '0;
            buf_q       <= '0;
            if_rdata    <= '0;
            d_rdata     <= '0;
            if_rvalid   <= 1'b0;
            d_done      <= 1'b0;
        end else begin
            if_rvalid <= 1'b0;
            d_done    <= 1'b0;
            if (if_gnt || d_gnt) begin
                base_q      <= if_gnt ? if_addr[M+1:2] : d_addr[M+1:2];
                src_data_q  <= d_gnt;
                last_data_q <= d_gnt;
                we_q        <= d_gnt && d_we;
            end
            if (d_gnt) wdata_q <= d_wdata;
            if (state_q == StXfer) begin
                // Sync read: the byte addressed last cycle is on mem_rdata now.
                if (!we_q && cnt_q != 2'd0) buf_q[{cnt_q - 2'd1, 3'b000} +: 8] <= mem_rdata;
                if (we_q && cnt_q == 2'd3) d_done <= 1'b1;
            end
            if (state_q == StDrain) begin
                if (src_data_q) begin
                    d_rdata <= {mem_rdata, buf_q};
                    d_done  <= 1'b1;
                end else begin
                    if_rdata  <= {mem_rdata, buf_q};
                    if_rvalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: byte memory model, reference memory and
// per-port scoreboards of expected words and completion cycles.
module tb_mem_port_arbiter;

    localparam int unsigned N = 32;
    localparam int unsigned M = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         halted, if_req, d_req, d_we;
    logic [M+1:0] if_addr, d_addr, mem_addr;
    logic [N-1:0] d_wdata, if_rdata, d_rdata;
    logic         if_gnt, if_rvalid, d_gnt, d_done, mem_we, busy;
    logic [7:0]   mem_wdata, mem_rdata;

    logic [7:0]   mem [4096];
    logic [7:0]   ref_mem [4096];
    logic         pre_we = 1'b0;
    logic [M+1:0] pre_addr = '0;
    logic [7:0]   pre_data = '0;

    typedef struct {logic [31:0] data; int due; logic chk_data;} exp_t;
    typedef struct {logic is_data; int cyc;} gnt_t;
    exp_t if_q[$];
    exp_t d_q[$];
    gnt_t gnt_log[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int we_cnt = 0;
    int if_gnt_cnt = 0;

    mem_port_arbiter #(.N(N), .M(M)) dut (
        .clk(clk), .rst(rst), .halted(halted),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [M+1:0] a);
        logic [M+1:0] b;
        b = {a[M+1:2], 2'b00};
        return {ref_mem[b + 3], ref_mem[b + 2], ref_mem[b + 1], ref_mem[b]};
    endfunction

    // Scoreboard: push expectations on grants, pop and compare on completions.
    always @(negedge clk) begin
        if (rst) begin
            exp_t e;
            if (mem_we) we_cnt++;
            if (if_gnt) begin
                if_gnt_cnt++;
                e.data = ref_word(if_addr); e.due = cyc + 6; e.chk_data = 1'b1;
                if_q.push_back(e);
                gnt_log.push_back('{1'b0, cyc});
            end
            if (d_gnt) begin
                logic [M+1:0] b;
                b = {d_addr[M+1:2], 2'b00};
                if (d_we) begin
                    for (int i = 0; i < 4; i++) ref_mem[b + i] = d_wdata[8*i +: 8];
                    e.data = '0; e.due = cyc + 5; e.chk_data = 1'b0;
                end else begin
                    e.data = ref_word(d_addr); e.due = cyc + 6; e.chk_data = 1'b1;
                end
                d_q.push_back(e);
                gnt_log.push_back('{1'b1, cyc});
            end
            if (if_rvalid) begin
                if (if_q.size() == 0) check_eq("if_rvalid_unexpected", 1, 0);
                else begin
                    e = if_q.pop_front();
                    check_eq("if_latency", cyc, e.due);
                    check_eq("if_rdata", if_rdata, e.data);
                end
            end
            if (d_done) begin
                if (d_q.size() == 0) check_eq("d_done_unexpected", 1, 0);
                else begin
                    e = d_q.pop_front();
                    check_eq("d_latency", cyc, e.due);
                    if (e.chk_data) check_eq("d_rdata", d_rdata, e.data);
                end
            end
        end
    end

    task automatic preload(input logic [M+1:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        ref_mem[a] = d;
        @(posedge clk) #1;
        pre_we = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [M+1:0] a, input logic [31:0] wd,
                           output int gcyc);
        bit got;
        got = 1'b0;
        @(posedge clk) #1;
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (d_gnt) begin got = 1'b1; gcyc = cyc; end
        end
        if (!got) check_eq("d_gnt_timeout", 0, 1);
        @(posedge clk) #1;
        d_req = 1'b0;
    endtask

    task automatic do_fetch(input logic [M+1:0] a);
        bit got;
        got = 1'b0;
        @(posedge clk) #1;
        if_req = 1'b1; if_addr = a;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (if_gnt) got = 1'b1;
        end
        if (!got) check_eq("if_gnt_timeout", 0, 1);
        @(posedge clk) #1;
        if_req = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (!busy && if_q.size() == 0 && d_q.size() == 0) ok = 1'b1;
        end
        if (!ok) check_eq("idle_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if_q.delete(); d_q.delete();
        rst = 1'b1;
    endtask

    initial begin
        int g, t1, t2, c0;
        bit got;
        rst = 1'b0; halted = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        preload(0, 8'h11); preload(1, 8'h22); preload(2, 8'h33); preload(3, 8'h44);
        #1;
        check_eq("reset_outputs", {if_gnt, d_gnt, busy, mem_we, if_rvalid, d_done},
                 6'b0);
        check_eq("reset_mem_addr", 32'(mem_addr), 0);
        do_reset();

        // 1: fetch of preloaded word
        do_fetch(0);
        wait_idle();
        check_eq("fetch_word", if_rdata, 32'h44332211);

        // 2: store then load from an unaligned address in the same word
        we_cnt = 0;
        do_data(1'b1, 12'h010, 32'hDEADBEEF, g);
        wait_idle();
        check_eq("store_we_cycles", we_cnt, 4);
        check_eq("store_bytes", {mem[12'h013], mem[12'h012], mem[12'h011], mem[12'h010]},
                 32'hDEADBEEF);
        do_data(1'b0, 12'h013, 32'h0, g);
        wait_idle();
        check_eq("load_word", d_rdata, 32'hDEADBEEF);

        // 3: both requesters held through reset alternate fetch/data back to back
        rst = 1'b0;
        if_req = 1'b1; if_addr = 12'h000; d_req = 1'b1; d_we = 1'b0; d_addr = 12'h010;
        @(negedge clk);
        check_eq("gnt_in_reset", {if_gnt, d_gnt}, 2'b00);
        gnt_log.delete();
        do_reset();
        for (int i = 0; i < 200 && gnt_log.size() < 4; i++) @(negedge clk);
        if_req = 1'b0; d_req = 1'b0;
        check_eq("rr_count", gnt_log.size(), 4);
        if (gnt_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check_eq("rr_order", 32'(gnt_log[i].is_data), 32'(i % 2));
                if (i > 0) check_eq("rr_gap", gnt_log[i].cyc - gnt_log[i-1].cyc, 6);
            end
        end
        wait_idle();

        // 4: halted blocks fetch grants but not data
        @(posedge clk) #1;
        halted = 1'b1; if_req = 1'b1; if_addr = 12'h010;
        if_gnt_cnt = 0; c0 = cyc;
        do_data(1'b0, 12'h000, 32'h0, g);
        while (cyc < c0 + 20) @(negedge clk);
        wait_idle();
        check_eq("halted_no_if_gnt", if_gnt_cnt, 0);
        @(posedge clk) #1;
        halted = 1'b0;
        @(negedge clk);
        check_eq("unhalt_if_gnt", if_gnt, 1);
        @(posedge clk) #1;
        if_req = 1'b0;
        wait_idle();
        check_eq("unhalt_fetch", if_rdata, 32'hDEADBEEF);

        // 5: reset in the middle of a store
        do_data(1'b1, 12'h020, 32'hCAFEF00D, g);
        @(posedge clk) #1;
        check_eq("store_we_t2", mem_we, 1);
        rst = 1'b0;
        #1;
        check_eq("rst_we_async", mem_we, 0);
        check_eq("rst_busy_async", busy, 0);
        do_reset();
        repeat (8) @(negedge clk);
        check_eq("no_done_after_rst", d_q.size(), 0);
        do_data(1'b1, 12'h020, 32'hCAFEF00D, g);
        wait_idle();
        do_data(1'b0, 12'h022, 32'h0, g);
        wait_idle();
        check_eq("retry_load", d_rdata, 32'hCAFEF00D);

        // 6: held second load is granted in the cycle of the first done
        @(posedge clk) #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h000;
        got = 1'b0; t1 = 0; t2 = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (d_gnt) begin got = 1'b1; t1 = cyc; end
        end
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (d_gnt) begin
                got = 1'b1; t2 = cyc;
                check_eq("b2b_done_with_gnt", d_done, 1);
            end
        end
        check_eq("b2b_gap", t2 - t1, 6);
        @(posedge clk) #1;
        d_req = 1'b0;
        wait_idle();
        check_eq("b2b_load", d_rdata, 32'h44332211);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
